// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 8N1 UART receiver (LSB first, idle-high) feeding a small
//            valid/ready receive FIFO, with false-start, framing and overrun
//            detection.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ  = 12000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW:0]   C_FULL      = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_frame_err;
  logic            r_overrun;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW:0]     r_count;

  logic w_bit_done;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_wr;

  assign w_bit_done = (r_clk_cnt == C_BIT_LAST);
  assign w_push     = (r_state == S_STOP) && w_bit_done && r_sync2;
  assign w_pop      = (r_count != '0) && rx_ready;
  assign w_full     = (r_count == C_FULL);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_wr       = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= rx;
      r_sync2     <= r_sync1;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_sync2) begin
            r_clk_cnt <= '0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (r_clk_cnt == C_HALF_LAST) begin
            r_clk_cnt <= '0;
            if (r_sync2) begin
              r_state <= S_IDLE;
            end else begin
              r_bit_idx <= '0;
              r_state   <= S_DATA;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_idx] <= r_sync2;
            r_bit_idx          <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            if (r_sync2) begin
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          // Held-low line (break) must return high before a new start is armed.
          if (r_sync2) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_mem[r_wptr] <= r_shift;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_data    = r_mem[r_rptr];
  assign rx_valid   = (r_count != '0);
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE);
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed, table-driven self-checking bench for uart_rx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_count;

  int n_tests  = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int both_cnt = 0;
  int base_e;
  int base_o;

  uart_rx_fifo #(
    .CLK_FREQ_HZ (160000),
    .BAUD        (10000),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (frame_err && overrun) both_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_cnt;
    int         exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives n_clk clocks of a start/8 data/stop frame; beyond the frame the stop level is held.
  // rx_ready is pulsed high for the one cycle starting at clock index pop_at.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int pop_at, input int n_clk);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < n_clk; i++) begin
      rx = (i < FRAME) ? f[i / CPB] : stop;
      if (i == pop_at) rx_ready = 1'b1;
      else if (i == pop_at + 1) rx_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk({name, " valid"}, rx_valid, 1);
    chk({name, " data"}, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h34, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'hA5, 1'b1, 1, 0};
    vecs[4] = '{8'hC3, 1'b0, 0, 1};
    vecs[5] = '{8'h80, 1'b1, 1, 0};

    rx = 1'b1;
    rx_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset rx_data", rx_data, 0);
    chk("reset count", fifo_count, 0);
    chk("reset busy", busy, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      base_e = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop, -1, FRAME);
      idle(2 * CPB);
      chk($sformatf("vec%0d count", i), fifo_count, vecs[i].exp_cnt);
      chk($sformatf("vec%0d frame_err", i), ferr_cnt - base_e, vecs[i].exp_err);
      if (vecs[i].exp_cnt != 0) begin
        pop_chk($sformatf("vec%0d pop", i), vecs[i].data);
        chk($sformatf("vec%0d empty", i), rx_valid, 0);
      end
    end

    // back-to-back frames
    send_frame(8'h34, 1'b1, -1, FRAME);
    send_frame(8'h32, 1'b1, -1, FRAME);
    send_frame(8'h0A, 1'b1, -1, FRAME);
    idle(CPB);
    chk("b2b count", fifo_count, 3);
    pop_chk("b2b pop0", 8'h34);
    pop_chk("b2b pop1", 8'h32);
    pop_chk("b2b pop2", 8'h0A);
    chk("b2b empty", rx_valid, 0);

    // false start: glitch shorter than half a bit
    base_e = ferr_cnt;
    base_o = ovr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("fstart busy", busy, 1);
    idle(2 * CPB);
    chk("fstart idle", busy, 0);
    chk("fstart count", fifo_count, 0);
    chk("fstart frame_err", ferr_cnt - base_e, 0);
    chk("fstart overrun", ovr_cnt - base_o, 0);

    // framing error with line held low, then recovery
    base_e = ferr_cnt;
    send_frame(8'h55, 1'b0, -1, FRAME + 2 * CPB);
    chk("ferr wait_idle busy", busy, 1);
    chk("ferr pulses", ferr_cnt - base_e, 1);
    chk("ferr count", fifo_count, 0);
    idle(CPB);
    chk("ferr released", busy, 0);
    send_frame(8'h41, 1'b1, -1, FRAME);
    idle(CPB);
    chk("ferr next count", fifo_count, 1);
    pop_chk("ferr next", 8'h41);

    // overrun on fifth byte
    base_o = ovr_cnt;
    for (int d = 1; d <= 5; d++) send_frame(8'(d), 1'b1, -1, FRAME);
    idle(CPB);
    chk("ovr pulses", ovr_cnt - base_o, 1);
    chk("ovr count", fifo_count, DEPTH);
    for (int d = 1; d <= 4; d++) pop_chk($sformatf("ovr pop%0d", d), 8'(d));
    chk("ovr empty", rx_valid, 0);

    // same, but pop on the exact push cycle of the fifth byte
    base_o = ovr_cnt;
    for (int d = 1; d <= 4; d++) send_frame(8'(d), 1'b1, -1, FRAME);
    send_frame(8'h05, 1'b1, FRAME - 6, FRAME);
    idle(CPB);
    chk("ovr2 pulses", ovr_cnt - base_o, 0);
    chk("ovr2 count", fifo_count, DEPTH);
    for (int d = 2; d <= 5; d++) pop_chk($sformatf("ovr2 pop%0d", d), 8'(d));
    chk("ovr2 empty", rx_valid, 0);

    // reset in the middle of data bit 4
    send_frame(8'h22, 1'b1, -1, FRAME);
    idle(CPB);
    chk("mid pre count", fifo_count, 1);
    send_frame(8'h7E, 1'b1, -1, 5 * CPB + CPB / 2);
    chk("mid pre busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid rst count", fifo_count, 0);
    chk("mid rst valid", rx_valid, 0);
    chk("mid rst data", rx_data, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst frame_err", frame_err, 0);
    chk("mid rst overrun", overrun, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(CPB);
    send_frame(8'h31, 1'b1, -1, FRAME);
    idle(CPB);
    chk("post rst count", fifo_count, 1);
    pop_chk("post rst", 8'h31);
    chk("post rst empty", fifo_count, 0);

    chk("flags never together", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
